wb_dual_master_arbiter: RTL and testbench
=========================================

Name: wb_dual_master_arbiter

Overview:
Shares one external Wishbone slave port between the CPU's two Wishbone master interfaces: data (master D) and instruction fetch (master I).
- Sits between the two Wishbone bus-interface instances and the SoC bus.
- Grants the bus to exactly one master at a time and holds the grant for the full cyc_o envelope.
- Routes the slave's ack and read data back to the granted master only.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width; select width is DATA_W/8

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
d_addr_i  in  ADDR_W  master D address
d_data_i  in  DATA_W  master D write data
d_we_i  in  1  master D write enable
d_sel_i  in  DATA_W/8  master D byte selects
d_stb_i  in  1  master D strobe
d_cyc_i  in  1  master D cycle (request)
d_data_o  out  DATA_W  read data to master D
d_ack_o  out  1  ack to master D
i_addr_i, i_data_i, i_we_i, i_sel_i, i_stb_i, i_cyc_i  in  (same widths as master D)  master I request signals
i_data_o  out  DATA_W  read data to master I
i_ack_o  out  1  ack to master I
s_addr_o  out  ADDR_W  slave address
s_data_o  out  DATA_W  slave write data
s_we_o  out  1  slave write enable
s_sel_o  out  DATA_W/8  slave byte selects
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
s_data_i  in  DATA_W  slave read data
s_ack_i  in  1  slave ack
grant_o  out  2  one-hot grant status: bit0 = D, bit1 = I

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- On reset:
  - State goes to IDLE and grant_o = 2'b00.
  - All s_* outputs are 0; d_ack_o = i_ack_o = 0; d_data_o = i_data_o = 0.
- States: IDLE, GNT_D, GNT_I.
- IDLE transitions:
  - d_cyc_i=1 → GNT_D.
  - d_cyc_i=0 and i_cyc_i=1 → GNT_I.
  - Both 0 → stay in IDLE.
  - Both requesting: D wins (fixed priority).
- GNT_x holds while x_cyc_i=1, regardless of the other master; this allows multi-beat and wait-stated cycles.
- Release: in the cycle where the granted master's cyc=0:
  - If the other master's cyc=1, the next state is the other master's GNT (direct handoff, no IDLE bubble).
  - Otherwise the next state is IDLE.
- Latency: a request first sampled in IDLE at edge N gives s_cyc_o/s_stb_o high from cycle N+1. The grant is registered; there is no combinational path from request to grant.
- Forward path (combinational from state):
  - In GNT_x: s_addr/data/we/sel/stb/cyc_o = master x's inputs.
  - In IDLE: all s_* outputs are 0.
- Return path (combinational):
  - x_ack_o = s_ack_i only when in GNT_x; otherwise 0.
  - x_data_o = s_data_i only when in GNT_x; otherwise 0.
- An s_ack_i arriving in IDLE is dropped; no master sees it.
- The ungranted master sees ack=0 and therefore stalls through its own bus interface. The arbiter never queues requests.
- Reset mid-transaction: the next state is IDLE and s_cyc_o drops in the following cycle. Any late slave ack is discarded per the IDLE rule.
- grant_o is the registered one-hot state: IDLE = 00, GNT_D = 01, GNT_I = 10. The value 11 is illegal and never produced.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant flop (reset value = I) records the master of the most recent grant.
  - On a simultaneous request in IDLE, the master that was NOT last granted wins.
  - Handoff behaviour is unchanged.
- Undefined: fixed D-over-I priority; no last_grant flop exists.

Decomposition:
- Package wb_arb_pkg holds:
  - State localparams ARB_IDLE=2'b00, ARB_GNT_D=2'b01, ARB_GNT_I=2'b10.
  - Master index constants M_D=0, M_I=1.
- One sub-module, wb_arb_mux: purely combinational forward/return routing selected by the state; the parent holds the FSM.

Test Plan:
- Reset: with rst=1 for 2 cycles and both cycs high → grant_o=00, s_cyc_o=0, both acks 0; release rst → grant_o=01 next cycle.
- Single I read: i_cyc/stb=1, addr 0xBFC00000; slave acks 2 cycles later with 0x3C08BFC0 → i_ack_o=1 with i_data_o=0x3C08BFC0, d_ack_o=0; i_cyc drops → grant_o=00 next cycle.
- Simultaneous D write/I read from IDLE, fixed priority: s_addr_o = d_addr (0x80001000), s_we_o=1, s_sel_o=4'b1111; when d_cyc drops → grant moves directly to I (grant_o 01→10, no 00 cycle).
- Lock: in GNT_I with a 5-cycle wait-stated slave, assert d_cyc mid-cycle → grant stays 10 until i_cyc=0, and d_ack_o stays 0 throughout.
- Stray ack: s_ack_i=1 while in IDLE → d_ack_o=i_ack_o=0; reset asserted during GNT_D → s_cyc_o=0 the next cycle and the ack that follows is dropped.
- With ARB_ROUND_ROBIN_EN: three back-to-back simultaneous requests from IDLE → grants alternate D, I, D (first D because last_grant resets to I).

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: state encodings and master indices shared by the dual-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_D = 2'b01,
    ARB_GNT_I = 2'b10
  } arb_state_t;
  localparam int M_D = 0;
  localparam int M_I = 1;
endpackage

// File: rtl/wb_arb_mux.sv
// wb_arb_mux: combinational forward and return routing between two masters and one slave, selected by arbiter state
module wb_arb_mux
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  arb_state_t          state,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_data_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic                d_stb_i,
  input  logic                d_cyc_i,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                d_ack_o,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_data_i,
  input  logic                i_we_i,
  input  logic [DATA_W/8-1:0] i_sel_i,
  input  logic                i_stb_i,
  input  logic                i_cyc_i,
  output logic [DATA_W-1:0]   i_data_o,
  output logic                i_ack_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_data_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i
);
  logic gd, gi;
  always_comb begin
    gd       = state == ARB_GNT_D;
    gi       = state == ARB_GNT_I;
    s_addr_o = gd ? d_addr_i : gi ? i_addr_i : '0;
    s_data_o = gd ? d_data_i : gi ? i_data_i : '0;
    s_we_o   = gd ? d_we_i   : gi & i_we_i;
    s_sel_o  = gd ? d_sel_i  : gi ? i_sel_i  : '0;
    s_stb_o  = gd ? d_stb_i  : gi & i_stb_i;
    s_cyc_o  = gd ? d_cyc_i  : gi & i_cyc_i;
    d_ack_o  = gd & s_ack_i;
    i_ack_o  = gi & s_ack_i;
    d_data_o = gd ? s_data_i : '0;
    i_data_o = gi ? s_data_i : '0;
  end
endmodule

// File: rtl/wb_dual_master_arbiter.sv
// wb_dual_master_arbiter: shares one Wishbone slave between data (D) and instruction (I) masters, grant held for the whole cyc envelope
// Define ARB_ROUND_ROBIN_EN to resolve simultaneous requests from IDLE by alternation instead of D-first priority.
module wb_dual_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_data_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_sel_i,
  input  logic                d_stb_i,
  input  logic                d_cyc_i,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                d_ack_o,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_data_i,
  input  logic                i_we_i,
  input  logic [DATA_W/8-1:0] i_sel_i,
  input  logic                i_stb_i,
  input  logic                i_cyc_i,
  output logic [DATA_W-1:0]   i_data_o,
  output logic                i_ack_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_data_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_ack_i,
  output logic [1:0]          grant_o
);
  arb_state_t state, idle_nxt, nxt;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  always_comb begin
    idle_nxt = d_cyc_i & i_cyc_i ? (last_grant == 1'(M_D) ? ARB_GNT_I : ARB_GNT_D)
             : d_cyc_i ? ARB_GNT_D : i_cyc_i ? ARB_GNT_I : ARB_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'(M_I);
    else if (nxt != ARB_IDLE && nxt != state) last_grant <= nxt == ARB_GNT_D ? 1'(M_D) : 1'(M_I);
  end
`else
  always_comb begin
    idle_nxt = d_cyc_i ? ARB_GNT_D : i_cyc_i ? ARB_GNT_I : ARB_IDLE;
  end
`endif
  // The owner keeps the bus while its cyc stays high; on release the other master takes over with no idle cycle.
  always_comb begin
    nxt = state == ARB_GNT_D ? (d_cyc_i ? ARB_GNT_D : i_cyc_i ? ARB_GNT_I : ARB_IDLE)
        : state == ARB_GNT_I ? (i_cyc_i ? ARB_GNT_I : d_cyc_i ? ARB_GNT_D : ARB_IDLE)
        : idle_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else state <= nxt;
  end
  assign grant_o = state;
  wb_arb_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .state(state),
    .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
    .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// tb_wb_dual_master_arbiter: directed checks of grant sequencing, routing, locking and stray-ack handling
module tb_wb_dual_master_arbiter;
  logic        clk = 0, rst = 1;
  logic [31:0] d_addr_i = 0, d_data_i = 0, i_addr_i = 0, i_data_i = 0, s_data_i = 0;
  logic        d_we_i = 0, d_stb_i = 0, d_cyc_i = 0, i_we_i = 0, i_stb_i = 0, i_cyc_i = 0, s_ack_i = 0;
  logic [3:0]  d_sel_i = 0, i_sel_i = 0;
  logic [31:0] d_data_o, i_data_o, s_addr_o, s_data_o;
  logic        d_ack_o, i_ack_o, s_we_o, s_stb_o, s_cyc_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;
  int n = 0, errs = 0;

  wb_dual_master_arbiter dut (
    .clk(clk), .rst(rst),
    .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
    .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    d_cyc_i = 1; i_cyc_i = 1;
    tick(); tick();
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_scyc", 64'(s_cyc_o), 64'h0);
    chk("rst_dack", 64'(d_ack_o), 64'h0);
    chk("rst_iack", 64'(i_ack_o), 64'h0);
    chk("rst_saddr", 64'(s_addr_o), 64'h0);
    rst = 0;
    tick();
    chk("post_rst_grant", 64'(grant_o), 64'h1);
    chk("post_rst_scyc", 64'(s_cyc_o), 64'h1);
    d_cyc_i = 0; i_cyc_i = 0;
    tick();
    chk("idle_grant", 64'(grant_o), 64'h0);
    // single instruction fetch with two-cycle slave latency
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'hBFC00000; i_sel_i = 4'hF;
    tick();
    chk("ird_grant", 64'(grant_o), 64'h2);
    chk("ird_saddr", 64'(s_addr_o), 64'hBFC00000);
    chk("ird_sstb", 64'(s_stb_o), 64'h1);
    tick();
    s_ack_i = 1; s_data_i = 32'h3C08BFC0;
    #1;
    chk("ird_iack", 64'(i_ack_o), 64'h1);
    chk("ird_idata", 64'(i_data_o), 64'h3C08BFC0);
    chk("ird_dack", 64'(d_ack_o), 64'h0);
    chk("ird_ddata", 64'(d_data_o), 64'h0);
    tick();
    s_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    tick();
    chk("ird_release", 64'(grant_o), 64'h0);
    // simultaneous D write and I read: D first, then direct handoff
    d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = 4'hF; d_addr_i = 32'h80001000; d_data_i = 32'hDEADBEEF;
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'hBFC00004;
    tick();
    chk("sim_grant", 64'(grant_o), 64'h1);
    chk("sim_saddr", 64'(s_addr_o), 64'h80001000);
    chk("sim_swe", 64'(s_we_o), 64'h1);
    chk("sim_ssel", 64'(s_sel_o), 64'hF);
    chk("sim_sdata", 64'(s_data_o), 64'hDEADBEEF);
    s_ack_i = 1; s_data_i = 32'h11112222;
    #1;
    chk("sim_dack", 64'(d_ack_o), 64'h1);
    chk("sim_iack", 64'(i_ack_o), 64'h0);
    chk("sim_idata", 64'(i_data_o), 64'h0);
    tick();
    s_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
    tick();
    chk("handoff_grant", 64'(grant_o), 64'h2);
    chk("handoff_saddr", 64'(s_addr_o), 64'hBFC00004);
    chk("handoff_swe", 64'(s_we_o), 64'h0);
    // D requests mid-cycle while I is held by a wait-stated slave
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h80002000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lock_grant", 64'(grant_o), 64'h2);
      chk("lock_dack", 64'(d_ack_o), 64'h0);
    end
    s_ack_i = 1; s_data_i = 32'h24020001;
    #1;
    chk("lock_iack", 64'(i_ack_o), 64'h1);
    chk("lock_dack_on_ack", 64'(d_ack_o), 64'h0);
    tick();
    s_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    tick();
    chk("lock_handoff", 64'(grant_o), 64'h1);
    chk("lock_handoff_saddr", 64'(s_addr_o), 64'h80002000);
    // reset in the middle of a D transaction, then a late ack
    rst = 1;
    tick();
    chk("midrst_scyc", 64'(s_cyc_o), 64'h0);
    chk("midrst_grant", 64'(grant_o), 64'h0);
    s_ack_i = 1;
    #1;
    chk("midrst_dack", 64'(d_ack_o), 64'h0);
    rst = 0; d_cyc_i = 0; d_stb_i = 0;
    tick();
    chk("stray_grant", 64'(grant_o), 64'h0);
    chk("stray_dack", 64'(d_ack_o), 64'h0);
    chk("stray_iack", 64'(i_ack_o), 64'h0);
    chk("stray_ddata", 64'(d_data_o), 64'h0);
    s_ack_i = 0;
`ifdef ARB_ROUND_ROBIN_EN
    rst = 1;
    tick();
    rst = 0;
    d_cyc_i = 1; i_cyc_i = 1;
    tick();
    chk("rr_first", 64'(grant_o), 64'h1);
    d_cyc_i = 0; i_cyc_i = 0;
    tick();
    d_cyc_i = 1; i_cyc_i = 1;
    tick();
    chk("rr_second", 64'(grant_o), 64'h2);
    d_cyc_i = 0; i_cyc_i = 0;
    tick();
    d_cyc_i = 1; i_cyc_i = 1;
    tick();
    chk("rr_third", 64'(grant_o), 64'h1);
    d_cyc_i = 0; i_cyc_i = 0;
    tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
